// File: rtl/controlador_imediato_pkg.sv
// Shared definitions for the immediate controller: FSM state codes, instruction
// classes and the opcode boundaries that separate them.
package controlador_imediato_pkg;

   localparam logic [1:0] OCIOSO     = 2'd0;
   localparam logic [1:0] DECODIFICA = 2'd1;
   localparam logic [1:0] ESTENDE    = 2'd2;
   localparam logic [1:0] ENTREGA    = 2'd3;

   typedef enum logic [1:0] {
      CLASSE_R      = 2'd0,
      CLASSE_I      = 2'd1,
      CLASSE_J      = 2'd2,
      CLASSE_ILEGAL = 2'd3
   } classe_t;

   localparam logic [5:0] LIMITE_I      = 6'h10;
   localparam logic [5:0] LIMITE_J      = 6'h20;
   localparam logic [5:0] LIMITE_ILEGAL = 6'h30;

   // Opcode ranges are contiguous blocks of 16, so three compares suffice.
   function automatic classe_t classifica(input logic [5:0] opcode);
      if (opcode < LIMITE_I)
         return CLASSE_R;
      else if (opcode < LIMITE_J)
         return CLASSE_I;
      else if (opcode < LIMITE_ILEGAL)
         return CLASSE_J;
      else
         return CLASSE_ILEGAL;
   endfunction

endpackage

// File: rtl/controlador_imediato_extensor.sv
// Zero-extends either the 14-bit (I) or the 23-bit (J) immediate field to 32 bits.
module ExtensorDeBits (
   input  logic        controle,
   input  logic [13:0] tamanho14,
   input  logic [22:0] tamanho23,
   output logic [31:0] saida
);

   assign saida = controle ? {9'b0, tamanho23} : {18'b0, tamanho14};

endmodule

// File: rtl/controlador_imediato.sv
// Four-state instruction immediate decoder with a valid/ready handshake on both
// sides and a free-running count of delivered results.
module controlador_imediato
   import controlador_imediato_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] imm,
   output logic [1:0]  tipo,
   output logic [4:0]  rd,
   output logic        ilegal,
   output logic [15:0] contagem
);

   logic [1:0]  estado;
   logic [31:0] instr_reg;
   logic        seletor;
   logic [31:0] estendido;

   assign seletor = (tipo == CLASSE_J);

   ExtensorDeBits extensor (
      .controle  (seletor),
      .tamanho14 (instr_reg[13:0]),
      .tamanho23 (instr_reg[22:0]),
      .saida     (estendido)
   );

   // in_ready and out_valid are kept as their own flops so every port comes
   // straight from a register; they always track the state they belong to.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado    <= OCIOSO;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         instr_reg <= '0;
         imm       <= '0;
         tipo      <= '0;
         rd        <= '0;
         ilegal    <= 1'b0;
         contagem  <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (in_valid) begin
                  instr_reg <= instr;
                  rd        <= instr[25:21];
                  in_ready  <= 1'b0;
                  estado    <= DECODIFICA;
               end
            end
            DECODIFICA: begin
               tipo   <= classifica(instr_reg[31:26]);
               rd     <= instr_reg[25:21];
               estado <= ESTENDE;
            end
            ESTENDE: begin
               if (tipo == CLASSE_I || tipo == CLASSE_J)
                  imm <= estendido;
               else
                  imm <= '0;
               ilegal    <= (tipo == CLASSE_ILEGAL);
               out_valid <= 1'b1;
               estado    <= ENTREGA;
            end
            ENTREGA: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  contagem  <= contagem + 16'd1;
                  estado    <= OCIOSO;
               end
            end
            default: begin
               estado    <= OCIOSO;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_imediato.sv
// Directed scoreboard bench for controlador_imediato: expected decodes are queued
// at acceptance and compared when the result is presented.
module tb_controlador_imediato;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] imm;
   logic [1:0]  tipo;
   logic [4:0]  rd;
   logic        ilegal;
   logic [15:0] contagem;

   typedef struct {
      logic [31:0] imm;
      logic [1:0]  tipo;
      logic [4:0]  rd;
      logic        ilegal;
   } esperado_t;

   esperado_t   fila[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cycle = 0;
   int          accCycle = 0;
   logic [15:0] contagemEsperada = '0;

   controlador_imediato dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm       (imm),
      .tipo      (tipo),
      .rd        (rd),
      .ilegal    (ilegal),
      .contagem  (contagem)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   // Reference decode written straight from the opcode table.
   function automatic esperado_t modelo(input logic [31:0] w);
      esperado_t   e;
      logic [5:0]  op;
      op       = w[31:26];
      e.rd     = w[25:21];
      e.ilegal = 1'b0;
      if (op < 6'h10) begin
         e.tipo = 2'd0;
         e.imm  = 32'h0;
      end else if (op < 6'h20) begin
         e.tipo = 2'd1;
         e.imm  = {18'b0, w[13:0]};
      end else if (op < 6'h30) begin
         e.tipo = 2'd2;
         e.imm  = {9'b0, w[22:0]};
      end else begin
         e.tipo   = 2'd3;
         e.imm    = 32'h0;
         e.ilegal = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offers one instruction when in_ready is seen; returns at the negedge after acceptance.
   task automatic applyStimulus(input logic [31:0] w);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("espera_in_ready", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      instr    = w;
      fila.push_back(modelo(w));
      @(negedge clock);
      accCycle = cycle;
      in_valid = 1'b0;
      instr    = $urandom;
   endtask

   // Waits for the result, compares it, optionally stalls, then takes it.
   task automatic checkOutput(input int stall);
      esperado_t e;
      int        n;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      // Seen at the negedge after edge k+2, so valid is present at edge k+3.
      chk("latencia", cycle - accCycle, 32'd2);
      if (fila.size() == 0) begin
         chk("fila_vazia", 32'd0, 32'd1);
         return;
      end
      e = fila.pop_front();
      chk("imm", imm, e.imm);
      chk("tipo", {30'b0, tipo}, {30'b0, e.tipo});
      chk("rd", {27'b0, rd}, {27'b0, e.rd});
      chk("ilegal", {31'b0, ilegal}, {31'b0, e.ilegal});
      chk("in_ready_ocupado", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         instr    = 32'h4000_0001;
         @(negedge clock);
         chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall_imm", imm, e.imm);
         chk("stall_tipo", {30'b0, tipo}, {30'b0, e.tipo});
         chk("stall_rd", {27'b0, rd}, {27'b0, e.rd});
         chk("stall_ilegal", {31'b0, ilegal}, {31'b0, e.ilegal});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      contagemEsperada++;
      chk("pos_out_valid", {31'b0, out_valid}, 32'd0);
      chk("pos_in_ready", {31'b0, in_ready}, 32'd1);
      chk("contagem", {16'b0, contagem}, {16'b0, contagemEsperada});
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      instr     = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_imm", imm, 32'h0);
      chk("rst_tipo", {30'b0, tipo}, 32'd0);
      chk("rst_rd", {27'b0, rd}, 32'd0);
      chk("rst_ilegal", {31'b0, ilegal}, 32'd0);
      chk("rst_contagem", {16'b0, contagem}, 32'd0);

      applyStimulus(32'h4060_3FFF);
      checkOutput(0);
      chk("i_imm_const", imm, 32'h0000_3FFF);
      chk("i_rd_const", {27'b0, rd}, 32'd3);

      applyStimulus(32'h847F_FFFF);
      checkOutput(0);
      applyStimulus(32'h8400_0001);
      checkOutput(0);
      chk("j_imm_const", imm, 32'h0000_0001);

      applyStimulus(32'hFC00_0000);
      checkOutput(0);
      applyStimulus(32'h0400_1234);
      checkOutput(0);

      applyStimulus(32'h5BE0_2A5A);
      checkOutput(5);

      applyStimulus(32'hBFFF_FFFF);
      checkOutput(1);

      // Reset while the instruction sits in ESTENDE.
      applyStimulus(32'h4060_0007);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      void'(fila.pop_back());
      contagemEsperada = '0;
      chk("rst_meio_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_meio_contagem", {16'b0, contagem}, 32'd0);
      chk("rst_meio_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (4) @(negedge clock);
      chk("rst_meio_descartado", {31'b0, out_valid}, 32'd0);

      // Preload the counter just below the wrap point.
      force dut.contagem = 16'hFFFF;
      @(negedge clock);
      release dut.contagem;
      @(negedge clock);
      contagemEsperada = 16'hFFFF;
      chk("preset_contagem", {16'b0, contagem}, 32'h0000_FFFF);
      applyStimulus(32'h8400_0002);
      checkOutput(0);
      chk("wrap_contagem", {16'b0, contagem}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/controlador_imediato.md
CONTROLADOR_IMEDIATO -- requirements
Module: controlador_imediato

Interface
REQ-001 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept an instruction
- instr  in  32  instruction word
- out_valid  out  1  decoded result available
- out_ready  in  1  consumer accepts the result
- imm  out  32  zero-extended immediate
- tipo  out  2  class: 0 = R, 1 = I, 2 = J, 3 = illegal
- rd  out  5  destination field instr[25:21]
- ilegal  out  1  opcode is in the illegal range
- contagem  out  16  count of delivered results
REQ-002 Parameters: none; all widths are fixed.

Function
REQ-003 Opcode is instr[31:26]. Classes:
- 0x00-0x0F: R, no immediate
- 0x10-0x1F: I, imm14 = instr[13:0]
- 0x20-0x2F: J, imm23 = instr[22:0]
- 0x30-0x3F: illegal
REQ-004 FSM states: OCIOSO, DECODIFICA, ESTENDE, ENTREGA; the encoding is not visible at the ports.
REQ-005 in_ready SHALL be 1 only in OCIOSO.
REQ-006 Acceptance occurs on a rising edge where in_valid=1 and in_ready=1: instr and rd are registered and the FSM moves to DECODIFICA.
REQ-007 DECODIFICA SHALL register tipo and drive the extender select (0 for I, 1 for J), then move unconditionally to ESTENDE.
REQ-008 ESTENDE SHALL register imm and ilegal, then move to ENTREGA:
- I or J: imm = extender output
- R or illegal: imm = 0x00000000
REQ-009 out_valid SHALL be 1 exactly in ENTREGA. For acceptance at edge k, out_valid is 1 from edge k+3.
REQ-010 While out_valid=1 and out_ready=0, imm, tipo, rd and ilegal SHALL hold stable.
REQ-011 On an edge with out_valid=1 and out_ready=1 the result transfers, contagem increments and the FSM returns to OCIOSO.
- Maximum throughput: one instruction per 4 cycles.
REQ-012 contagem SHALL wrap from 0xFFFF to 0x0000 without a flag. Illegal instructions are delivered and counted.
REQ-013 Extension SHALL be zero-extension only; no sign extension.
REQ-014 in_valid and instr SHALL be ignored outside OCIOSO. out_ready SHALL be ignored outside ENTREGA.
REQ-015 Every output SHALL be driven from a register; no input-to-output combinational path.

Reset
REQ-016 When reset=1 at a rising edge, the block SHALL enter OCIOSO with these values:
- in_ready = 1 (asserted in the first cycle after reset)
- out_valid = 0, imm = 0, tipo = 0, rd = 0, ilegal = 0, contagem = 0
REQ-017 Reset SHALL win over every other event. Reset mid-operation discards the in-flight instruction, which is neither delivered nor counted.

Structure
REQ-018 A shared package SHALL hold:
- the state enumeration
- the class codes
- the opcode range boundary constants 0x10, 0x20, 0x30
REQ-019 The block SHALL instantiate the existing ExtensorDeBits as its single sub-module:
- controle driven from the registered class
- tamanho14 = instr_reg[13:0]
- tamanho23 = instr_reg[22:0]
REQ-020 No other sub-modules; the FSM, output registers and counter are local.

Verification
REQ-021 I-type: instr=0x40603FFF accepted at edge k, out_ready=1 -> out_valid rises at k+3; imm=0x00003FFF, tipo=1, rd=3, ilegal=0; contagem goes 0 to 1.
REQ-022 J-type: instr=0x847FFFFF -> imm=0x007FFFFF, tipo=2, ilegal=0. Also 0x84000001 -> imm=0x00000001.
REQ-023 Illegal/R: instr=0xFC000000 -> tipo=3, ilegal=1, imm=0, contagem increments. instr=0x04001234 -> tipo=0, imm=0.
REQ-024 Backpressure: out_ready=0 for 5 cycles in ENTREGA -> outputs stable and in_ready=0 throughout; a new in_valid pulse is ignored. out_ready=1 -> one transfer, then in_ready=1.
REQ-025 Reset/wrap:
- reset asserted in ESTENDE -> next cycle out_valid=0, contagem=0, in_ready=1
- contagem preset to 0xFFFF through 65535 deliveries, one more delivery -> 0x0000
